// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM driver with off/steady/blink/breathe modes.
// Configuration is double-buffered and only switches at PWM frame boundaries.

module led_pwm_lane #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_100mhz,
  input  logic                reset_n,
  input  logic                boundary,
  input  logic                blink_msb,
  input  logic [PWM_BITS-1:0] blink_lo,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_o
);
  logic [PWM_BITS-1:0]   eff_q, eff_d;
  logic                  led_q, led_d;
  logic [PWM_BITS-1:0]   ramp;
  logic [2*PWM_BITS-1:0] prod;

  always_comb begin
    ramp  = blink_msb ? ~blink_lo : blink_lo;
    prod  = (2*PWM_BITS)'(duty) * (2*PWM_BITS)'(ramp);
    eff_d = eff_q;
    if (boundary) begin
      unique case (mode)
        2'b00:   eff_d = '0;
        2'b01:   eff_d = duty;
        2'b10:   eff_d = blink_msb ? '0 : duty;
        default: eff_d = prod[2*PWM_BITS-1:PWM_BITS];
      endcase
    end
    led_d = (pwm_cnt < eff_q) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      eff_q <= '0;
      led_q <= ACTIVE_LOW;
    end else begin
      eff_q <= eff_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pwm_ctrl #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1024,
  parameter int BLINK_BITS = 9,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                         clk_100mhz,
  input  logic                         reset_n,
  input  logic                         cfg_we,
  input  logic [CHANNELS*PWM_BITS-1:0] cfg_duty,
  input  logic [CHANNELS*2-1:0]        cfg_mode,
  output logic                         cfg_pending,
  output logic [CHANNELS-1:0]          led_o,
  output logic                         frame_start,
  output logic                         blink_phase
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]                     pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]                  pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0]                blink_cnt_q, blink_cnt_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]    shd_duty_q, shd_duty_d, act_duty_q, act_duty_d;
  logic [CHANNELS-1:0][1:0]             shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;
  logic                                 pending_q, pending_d;
  logic                                 frame_start_q, frame_start_d;
  logic                                 tick, boundary;

  always_comb begin
    tick        = (pre_cnt_q == PRE_W'(PRESCALE - 1));
    boundary    = tick && (&pwm_cnt_q);
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blink_cnt_d = boundary ? blink_cnt_q + BLINK_BITS'(1) : blink_cnt_q;

    shd_duty_d  = shd_duty_q;
    shd_mode_d  = shd_mode_q;
    act_duty_d  = act_duty_q;
    act_mode_d  = act_mode_q;
    pending_d   = pending_q;
    // Apply the old shadow first so a write landing on the boundary stays pending.
    if (boundary && pending_q) begin
      act_duty_d = shd_duty_q;
      act_mode_d = shd_mode_q;
      pending_d  = 1'b0;
    end
    if (cfg_we) begin
      shd_duty_d = cfg_duty;
      shd_mode_d = cfg_mode;
      pending_d  = 1'b1;
    end
    frame_start_d = boundary;
  end

  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      shd_duty_q    <= '0;
      shd_mode_q    <= '0;
      act_duty_q    <= '0;
      act_mode_q    <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      shd_duty_q    <= shd_duty_d;
      shd_mode_q    <= shd_mode_d;
      act_duty_q    <= act_duty_d;
      act_mode_q    <= act_mode_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Lanes see the post-boundary counter and configuration.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    led_pwm_lane #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk_100mhz (clk_100mhz),
      .reset_n    (reset_n),
      .boundary   (boundary),
      .blink_msb  (blink_cnt_d[BLINK_BITS-1]),
      .blink_lo   (blink_cnt_d[PWM_BITS-1:0]),
      .duty       (act_duty_d[c]),
      .mode       (act_mode_d[c]),
      .pwm_cnt    (pwm_cnt_q),
      .led_o      (led_o[c])
    );
  end

  assign cfg_pending = pending_q;
  assign frame_start = frame_start_q;
  assign blink_phase = blink_cnt_q[BLINK_BITS-1];
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: stimulus queues per-frame expectations,
// a negedge monitor measures each PWM frame and checks it against the queue.

module tb_led_pwm_ctrl;
  localparam int CH = 3;
  localparam int PB = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CH*PB-1:0] cfg_duty = '0;
  logic [CH*2-1:0]  cfg_mode = '0;
  logic            cfg_pending;
  logic [CH-1:0]   led_o;
  logic            frame_start;
  logic            blink_phase;

  led_pwm_ctrl #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(1), .BLINK_BITS(9), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_100mhz  (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_duty    (cfg_duty),
    .cfg_mode    (cfg_mode),
    .cfg_pending (cfg_pending),
    .led_o       (led_o),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int epoch;
    int frame;
    int on0, on1, on2;
    bit pend0, pend_end, phase;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int e, input int f, input int a, input int b, input int c,
                      input bit p0, input bit pe, input bit ph);
    exp_t x;
    x.epoch = e; x.frame = f; x.on0 = a; x.on1 = b; x.on2 = c;
    x.pend0 = p0; x.pend_end = pe; x.phase = ph;
    q.push_back(x);
  endtask

  task automatic at_cyc(input int t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic cfg_write(input int d0, input bit [1:0] m0, input int d1, input bit [1:0] m1,
                           input int d2, input bit [1:0] m2);
    cfg_duty = {PB'(d2), PB'(d1), PB'(d0)};
    cfg_mode = {m2, m1, m0};
    cfg_we   = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // Monitor: a frame's LED window is the 256 samples after its frame_start,
  // because led_o lags the counter by one cycle.
  int epoch = 0, fcnt = 0, nsamp = 0, st_cyc = 0;
  int acc [CH];
  bit in_rst = 1'b0, in_frame = 1'b0, st_pend = 1'b0, st_phase = 1'b0, last_pend = 1'b0;

  task automatic finalize();
    string tag;
    while (q.size() > 0 && (q[0].epoch < epoch || (q[0].epoch == epoch && q[0].frame < fcnt))) begin
      chk($sformatf("missed_frame_e%0d_f%0d", q[0].epoch, q[0].frame), 0, 1);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].epoch == epoch && q[0].frame == fcnt) begin
      tag = $sformatf("e%0d_f%0d", epoch, fcnt);
      chk({tag, "_start_cyc"}, st_cyc, 256 * fcnt);
      chk({tag, "_len"},       nsamp,  256);
      chk({tag, "_on0"},       acc[0], q[0].on0);
      chk({tag, "_on1"},       acc[1], q[0].on1);
      chk({tag, "_on2"},       acc[2], q[0].on2);
      chk({tag, "_pend0"},     int'(st_pend),   int'(q[0].pend0));
      chk({tag, "_pend_end"},  int'(last_pend), int'(q[0].pend_end));
      chk({tag, "_phase"},     int'(st_phase),  int'(q[0].phase));
      void'(q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        if (!in_rst) epoch++;
        in_rst = 1'b1; fcnt = 0; in_frame = 1'b0;
      end else begin
        in_rst = 1'b0;
        if (in_frame)
          for (int c = 0; c < CH; c++) if (led_o[c] == 1'b0) acc[c]++;
        if (in_frame) nsamp++;
        if (frame_start) begin
          if (in_frame) finalize();
          fcnt++;
          in_frame = 1'b1; nsamp = 0;
          for (int c = 0; c < CH; c++) acc[c] = 0;
          st_cyc = cyc; st_pend = cfg_pending; st_phase = blink_phase;
        end
        last_pend = cfg_pending;
      end
    end
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_led",         int'(led_o),       7);
    chk("rst_pending",     int'(cfg_pending), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_phase",       int'(blink_phase), 0);
    reset_n = 1'b1;

    // Steady duties, written during frame 0
    push(1, 1, 64, 0, 255, 0, 0, 0);
    at_cyc(10);
    cfg_write(64, 2'b01, 0, 2'b01, 255, 2'b01);

    // Shadow timing: two writes mid-frame 2, last one wins in frame 3
    push(1, 2, 64, 0, 255, 0, 1, 0);
    push(1, 3, 32, 0, 255, 0, 0, 0);
    at_cyc(512 + 100);
    cfg_write(200, 2'b01, 0, 2'b01, 255, 2'b01);
    at_cyc(512 + 150);
    cfg_write(32, 2'b01, 0, 2'b01, 255, 2'b01);

    // Boundary collision: A pending, B written on the boundary tick
    push(1, 4, 32, 0, 255, 0, 1, 0);
    push(1, 5, 16, 0, 255, 1, 1, 0);
    push(1, 6, 128, 0, 255, 0, 1, 0);
    at_cyc(1024 + 50);
    cfg_write(16, 2'b01, 0, 2'b01, 255, 2'b01);
    at_cyc(1279);
    cfg_write(128, 2'b01, 0, 2'b01, 255, 2'b01);

    // ch0 blink 128, ch1 breathe 255, ch2 off with nonzero duty
    push(1,   7, 128,   6, 0, 0, 0, 0);
    push(1, 100, 128,  99, 0, 0, 0, 0);
    push(1, 255, 128, 254, 0, 0, 0, 0);
    push(1, 256,   0, 254, 0, 0, 0, 1);
    push(1, 300,   0, 210, 0, 0, 0, 1);
    push(1, 356,   0, 154, 0, 0, 0, 1);
    at_cyc(1536 + 10);
    cfg_write(128, 2'b10, 255, 2'b11, 200, 2'b00);

    // Reset while a value is pending
    at_cyc(357 * 256 + 20);
    cfg_write(200, 2'b01, 200, 2'b01, 200, 2'b01);
    chk("pre_rst_pending", int'(cfg_pending), 1);
    push(2, 1, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_pending", int'(cfg_pending), 0);
    chk("rst2_led",     int'(led_o),       7);
    reset_n = 1'b1;
    at_cyc(520);

    while (q.size() > 0) begin
      chk($sformatf("unseen_frame_e%0d_f%0d", q[0].epoch, q[0].frame), 0, 1);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
